accelerator_fnn_neuron_accumulator: RTL and testbench
=====================================================

ACCELERATOR_FNN_NEURON_ACCUMULATOR -- requirements
Module: accelerator_fnn_neuron_accumulator

Interface
REQ-001 Parameter DATA_SIZE, default 64: signed two's-complement data, weight, bias and result width.
REQ-002 Parameter CONTROL_SIZE, default 4: width of the element-count port and the internal counter.
REQ-003 Parameter FRACT_SIZE, default 16: fractional bits of the fixed-point format, constrained 0 <= FRACT_SIZE < DATA_SIZE.
REQ-004 CLK  input  1: single clock; all state updates on its rising edge.
REQ-005 RST  input  1: asynchronous, active-low reset.
REQ-006 START  input  1: one-cycle request to begin a dot product; sampled only in IDLE.
REQ-007 SIZE_IN  input  CONTROL_SIZE: number of (weight, data) pairs N, latched on accepted START.
REQ-008 BIAS_IN  input  DATA_SIZE: bias b, latched on accepted START.
REQ-009 DATA_IN_ENABLE  input  1: valid strobe for the current W_IN/X_IN pair.
REQ-010 W_IN  input  DATA_SIZE: weight element.
REQ-011 X_IN  input  DATA_SIZE: data element.
REQ-012 DATA_ENABLE  output  1: high in INPUT state; element pairs are accepted on cycles where DATA_ENABLE and DATA_IN_ENABLE are both high.
REQ-013 DATA_OUT  output  DATA_SIZE: result b + sum(W[i]*X[i]) in fixed point; holds its value until the next READY.
REQ-014 READY  output  1: one-cycle pulse marking DATA_OUT valid.
REQ-015 OVERFLOW_OUT  output  1: sticky per-operation overflow flag, valid with READY.

Function
REQ-016 The FSM SHALL have states IDLE, INPUT and ENDER.
REQ-017 IDLE with START=1 SHALL latch SIZE_IN and BIAS_IN, load the accumulator with BIAS_IN, clear the counter and OVERFLOW_OUT, and go to INPUT; SIZE_IN=0 goes straight to ENDER.
REQ-018 INPUT SHALL accept one pair per cycle with DATA_IN_ENABLE=1; cycles with DATA_IN_ENABLE=0 stall, changing no state.
REQ-019 Each accepted pair SHALL form the full 2*DATA_SIZE signed product, arithmetic-shift it right by FRACT_SIZE, truncate it to DATA_SIZE, and add it to the accumulator in the same cycle.
REQ-020 Once the pair with counter = N-1 is accepted, the FSM SHALL go to ENDER; the counter SHALL never wrap within an operation.
REQ-021 ENDER SHALL drive DATA_OUT = accumulator, assert READY for exactly that cycle, and return to IDLE.
REQ-022 Latency: START to READY SHALL be N+1 cycles with no stalls, plus one per stall cycle; SIZE_IN=0 gives READY on the cycle after START.
REQ-023 START outside IDLE and DATA_IN_ENABLE outside INPUT SHALL be ignored.
REQ-024 A product overflow (shifted product outside DATA_SIZE signed range) or an accumulation overflow SHALL set OVERFLOW_OUT, which stays set until the next accepted START.
REQ-025 Back-to-back: START in the cycle after READY SHALL be accepted.

Reset
REQ-026 With RST=0, asynchronously: FSM to IDLE; DATA_OUT, accumulator, counter, latched size/bias all zero; READY, DATA_ENABLE and OVERFLOW_OUT all 0.
REQ-027 Reset during INPUT or ENDER SHALL abort the operation with no READY pulse; after RST releases, the first START begins a fresh operation.

Configuration
REQ-028 Macro ACCELERATOR_FNN_SATURATION_EN defined: on overflow, the product and the accumulator SHALL clamp to the maximum positive or minimum negative DATA_SIZE value according to the sign of the result.
REQ-029 Macro undefined: product truncation and addition SHALL wrap modulo 2^DATA_SIZE; OVERFLOW_OUT SHALL still report overflow.

Verification (DATA_SIZE=64, FRACT_SIZE=16, values given as real fixed-point)
REQ-030 N=3, b=1.0, W=(1.0,2.0,3.0), X=(0.5,0.5,1.0), enable on every cycle -> READY 4 cycles after START, DATA_OUT=5.5, OVERFLOW_OUT=0.
REQ-031 N=0, b=-2.0 -> READY on the cycle after START, DATA_OUT=-2.0.
REQ-032 N=2 with DATA_IN_ENABLE low for 3 cycles between the two pairs -> READY 6 cycles after START, result unaffected by the stall.
REQ-033 b = max positive value, one pair 1.0*1.0 -> OVERFLOW_OUT=1; DATA_OUT = max positive with the macro, wrapped negative value without it.
REQ-034 RST pulsed low after the first of 3 pairs -> no READY, outputs zero; a new N=1 operation then returns the correct result.
REQ-035 START held high during INPUT and repeated in the cycle after READY -> mid-operation START ignored, second operation accepted back-to-back.

Source files
------------

// File: rtl/accelerator_fnn_neuron_accumulator.sv
// Fixed-point neuron: DATA_OUT = bias + sum(W[i]*X[i]) over SIZE_IN pairs, IDLE/INPUT/ENDER FSM.
// Optional clamping on overflow when ACCELERATOR_FNN_SATURATION_EN is defined (wraps otherwise).
module accelerator_fnn_neuron_accumulator #(
    parameter int DATA_SIZE    = 64,
    parameter int CONTROL_SIZE = 4,
    parameter int FRACT_SIZE   = 16
) (
    input  logic                    CLK,
    input  logic                    RST,
    input  logic                    START,
    input  logic [CONTROL_SIZE-1:0] SIZE_IN,
    input  logic [DATA_SIZE-1:0]    BIAS_IN,
    input  logic                    DATA_IN_ENABLE,
    input  logic [DATA_SIZE-1:0]    W_IN,
    input  logic [DATA_SIZE-1:0]    X_IN,
    output logic                    DATA_ENABLE,
    output logic [DATA_SIZE-1:0]    DATA_OUT,
    output logic                    READY,
    output logic                    OVERFLOW_OUT,
    output logic [1:0]              debug_state
);

    // Handshake: a (W_IN, X_IN) pair is consumed on a rising edge where DATA_ENABLE and
    // DATA_IN_ENABLE are both high; READY is a single-cycle pulse with DATA_OUT valid.
    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] INPUT = 2'd1;
    localparam logic [1:0] ENDER = 2'd2;

    localparam int PW = 2 * DATA_SIZE;
    localparam logic [DATA_SIZE-1:0] MAX_VAL = {1'b0, {(DATA_SIZE-1){1'b1}}};
    localparam logic [DATA_SIZE-1:0] MIN_VAL = {1'b1, {(DATA_SIZE-1){1'b0}}};

    logic [1:0]              state;
    logic [1:0]              state_next;
    logic [CONTROL_SIZE-1:0] count;
    logic [CONTROL_SIZE-1:0] size_q;
    logic [DATA_SIZE-1:0]    acc;
    logic [DATA_SIZE-1:0]    data_out_q;
    logic                    overflow_q;

    logic signed [PW-1:0]    w_ext;
    logic signed [PW-1:0]    x_ext;
    logic signed [PW-1:0]    product_full;
    logic signed [PW-1:0]    product_shifted;
    logic [DATA_SIZE:0]      product_upper;
    logic [DATA_SIZE-1:0]    product_term;
    logic [DATA_SIZE-1:0]    sum_wrap;
    logic [DATA_SIZE-1:0]    sum_term;
    logic                    product_ovf;
    logic                    sum_ovf;
    logic                    last_pair;

    always_comb begin
        w_ext           = {{DATA_SIZE{W_IN[DATA_SIZE-1]}}, W_IN};
        x_ext           = {{DATA_SIZE{X_IN[DATA_SIZE-1]}}, X_IN};
        product_full    = w_ext * x_ext;
        product_shifted = product_full >>> FRACT_SIZE;
        // The shifted product fits only if every bit above the result sign matches it.
        product_upper   = product_shifted[PW-1:DATA_SIZE-1];
        product_ovf     = !((&product_upper) || !(|product_upper));
`ifdef ACCELERATOR_FNN_SATURATION_EN
        if (product_ovf) begin
            product_term = product_shifted[PW-1] ? MIN_VAL : MAX_VAL;
        end else begin
            product_term = product_shifted[DATA_SIZE-1:0];
        end
`else
        product_term = product_shifted[DATA_SIZE-1:0];
`endif
        sum_wrap = acc + product_term;
        sum_ovf  = (acc[DATA_SIZE-1] == product_term[DATA_SIZE-1]) &&
                   (sum_wrap[DATA_SIZE-1] != acc[DATA_SIZE-1]);
`ifdef ACCELERATOR_FNN_SATURATION_EN
        if (sum_ovf) begin
            sum_term = acc[DATA_SIZE-1] ? MIN_VAL : MAX_VAL;
        end else begin
            sum_term = sum_wrap;
        end
`else
        sum_term = sum_wrap;
`endif
    end

    assign last_pair = (count == (size_q - 1'b1));

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (START) begin
                    state_next = (SIZE_IN == '0) ? ENDER : INPUT;
                end
            end
            INPUT: begin
                if (DATA_IN_ENABLE && last_pair) begin
                    state_next = ENDER;
                end
            end
            ENDER:   state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // The accumulator is loaded with the bias on START, so it doubles as the bias latch.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state      <= IDLE;
            count      <= '0;
            size_q     <= '0;
            acc        <= '0;
            data_out_q <= '0;
            overflow_q <= 1'b0;
        end else begin
            state <= state_next;
            case (state)
                IDLE: begin
                    if (START) begin
                        size_q     <= SIZE_IN;
                        acc        <= BIAS_IN;
                        count      <= '0;
                        overflow_q <= 1'b0;
                    end
                end
                INPUT: begin
                    if (DATA_IN_ENABLE) begin
                        acc <= sum_term;
                        if (product_ovf || sum_ovf) begin
                            overflow_q <= 1'b1;
                        end
                        if (!last_pair) begin
                            count <= count + 1'b1;
                        end
                    end
                end
                ENDER: begin
                    data_out_q <= acc;
                end
                default: ;
            endcase
        end
    end

    // During ENDER the live accumulator is shown; afterwards the captured copy holds.
    assign DATA_ENABLE  = (state == INPUT);
    assign READY        = (state == ENDER);
    assign DATA_OUT     = (state == ENDER) ? acc : data_out_q;
    assign OVERFLOW_OUT = overflow_q;
    assign debug_state  = state;

endmodule

// File: tb/tb_accelerator_fnn_neuron_accumulator.sv
// Bench for accelerator_fnn_neuron_accumulator: directed table, reset abort, randomized ops vs model.
module tb_accelerator_fnn_neuron_accumulator;

  localparam int DW = 64;
  localparam int CW = 4;
  localparam int FW = 16;
`ifdef ACCELERATOR_FNN_SATURATION_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif
  localparam logic [DW-1:0] MAX64 = 64'h7FFF_FFFF_FFFF_FFFF;
  localparam logic [DW-1:0] MIN64 = 64'h8000_0000_0000_0000;
  localparam logic signed [127:0] MAXV = 128'sh7FFF_FFFF_FFFF_FFFF;
  localparam logic signed [127:0] MINV = -128'sh8000_0000_0000_0000;
  localparam logic [DW-1:0] ONE = 64'h10000;

  logic          CLK = 1'b0;
  logic          RST;
  logic          START;
  logic [CW-1:0] SIZE_IN;
  logic [DW-1:0] BIAS_IN;
  logic          DATA_IN_ENABLE;
  logic [DW-1:0] W_IN;
  logic [DW-1:0] X_IN;
  logic          DATA_ENABLE;
  logic [DW-1:0] DATA_OUT;
  logic          READY;
  logic          OVERFLOW_OUT;
  logic [1:0]    debug_state;

  accelerator_fnn_neuron_accumulator #(
    .DATA_SIZE(DW), .CONTROL_SIZE(CW), .FRACT_SIZE(FW)
  ) dut (
    .CLK(CLK), .RST(RST), .START(START), .SIZE_IN(SIZE_IN), .BIAS_IN(BIAS_IN),
    .DATA_IN_ENABLE(DATA_IN_ENABLE), .W_IN(W_IN), .X_IN(X_IN),
    .DATA_ENABLE(DATA_ENABLE), .DATA_OUT(DATA_OUT), .READY(READY),
    .OVERFLOW_OUT(OVERFLOW_OUT), .debug_state(debug_state)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    int                  n;
    logic [DW-1:0]       bias;
    logic [2:0][DW-1:0]  w;
    logic [2:0][DW-1:0]  x;
    int                  stall1;
    bit                  hold;
    logic [DW-1:0]       exp_out;
    bit                  exp_ovf;
    int                  exp_lat;
  } vec_t;

  vec_t          vecs[8];
  logic [DW-1:0] op_w[16];
  logic [DW-1:0] op_x[16];
  int            op_stall[17];
  bit            start_hold;
  logic [DW-1:0] last_out;
  bit            last_ovf;
  int            tests = 0;
  int            failed = 0;

  task automatic check64(input string name, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    tests++;
    if (got !== exp) begin
      failed++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic check_int(input string name, input int got, input int exp);
    tests++;
    if (got != exp) begin
      failed++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  function automatic vec_t mk(input int n, input logic [DW-1:0] b,
                              input logic [DW-1:0] w0, input logic [DW-1:0] w1, input logic [DW-1:0] w2,
                              input logic [DW-1:0] x0, input logic [DW-1:0] x1, input logic [DW-1:0] x2,
                              input int s1, input bit hold,
                              input logic [DW-1:0] eo, input bit ev, input int el);
    vec_t v;
    v.n = n; v.bias = b;
    v.w[0] = w0; v.w[1] = w1; v.w[2] = w2;
    v.x[0] = x0; v.x[1] = x1; v.x[2] = x2;
    v.stall1 = s1; v.hold = hold;
    v.exp_out = eo; v.exp_ovf = ev; v.exp_lat = el;
    return v;
  endfunction

  // Reference: exact wide arithmetic, range test, then wrap or clamp.
  function automatic void ref_model(input int n, input logic [DW-1:0] bias,
                                    output logic [DW-1:0] res, output bit ovf);
    logic signed [127:0] a, b, prod, sum;
    logic [DW-1:0] acc, term;
    acc = bias;
    ovf = 1'b0;
    for (int i = 0; i < n; i++) begin
      a = {{64{op_w[i][63]}}, op_w[i]};
      b = {{64{op_x[i][63]}}, op_x[i]};
      prod = (a * b) >>> FW;
      term = prod[63:0];
      if (prod > MAXV || prod < MINV) begin
        ovf = 1'b1;
        if (SAT) term = (prod < 0) ? MIN64 : MAX64;
      end
      sum = {{64{acc[63]}}, acc} + {{64{term[63]}}, term};
      acc = sum[63:0];
      if (sum > MAXV || sum < MINV) begin
        ovf = 1'b1;
        if (SAT) acc = (sum < 0) ? MIN64 : MAX64;
      end
    end
    res = acc;
  endfunction

  function automatic logic [DW-1:0] rand_val(input int big_pct);
    logic [DW-1:0] v;
    if ($urandom_range(0, 99) < big_pct) begin
      v = {$urandom, $urandom};
    end else begin
      v = {32'd0, $urandom_range(0, 1 << 20)} - 64'd524288;
    end
    return v;
  endfunction

  task automatic run_op(input int n, input logic [DW-1:0] bias,
                        output logic [DW-1:0] got_out, output bit got_ovf,
                        output int got_lat, output bit got_ready);
    int cyc;
    int idx;
    int stall_left;
    @(negedge CLK);
    check64("hold_data_out", DATA_OUT, last_out);
    check_int("hold_overflow", int'(OVERFLOW_OUT), int'(last_ovf));
    START = 1'b1;
    SIZE_IN = CW'(n);
    BIAS_IN = bias;
    DATA_IN_ENABLE = 1'b1;
    W_IN = {$urandom, $urandom};
    X_IN = {$urandom, $urandom};
    cyc = 0;
    idx = 0;
    stall_left = op_stall[0];
    got_ready = 1'b0;
    got_out = '0;
    got_ovf = 1'b0;
    got_lat = -1;
    while (cyc < 200 && !got_ready) begin
      @(negedge CLK);
      cyc++;
      START = start_hold;
      if (READY) begin
        got_ready = 1'b1;
        got_out = DATA_OUT;
        got_ovf = OVERFLOW_OUT;
        got_lat = cyc;
        DATA_IN_ENABLE = 1'b1;
        W_IN = {$urandom, $urandom};
        X_IN = {$urandom, $urandom};
      end else if (idx < n && stall_left > 0) begin
        DATA_IN_ENABLE = 1'b0;
        W_IN = {$urandom, $urandom};
        stall_left--;
      end else if (idx < n) begin
        DATA_IN_ENABLE = 1'b1;
        W_IN = op_w[idx];
        X_IN = op_x[idx];
        idx++;
        stall_left = op_stall[idx];
      end else begin
        DATA_IN_ENABLE = 1'b0;
      end
    end
    START = 1'b0;
    DATA_IN_ENABLE = 1'b0;
  endtask

  task automatic do_vec(input string tag, input int n, input logic [DW-1:0] bias,
                        input logic [DW-1:0] exp_out, input bit exp_ovf, input int exp_lat);
    logic [DW-1:0] got_out;
    bit got_ovf;
    bit got_ready;
    int got_lat;
    run_op(n, bias, got_out, got_ovf, got_lat, got_ready);
    check_int({tag, "_ready_seen"}, int'(got_ready), 1);
    check64({tag, "_data_out"}, got_out, exp_out);
    check_int({tag, "_overflow"}, int'(got_ovf), int'(exp_ovf));
    check_int({tag, "_latency"}, got_lat, exp_lat);
    last_out = exp_out;
    last_ovf = exp_ovf;
  endtask

  initial begin
    logic [DW-1:0] exp_out;
    bit exp_ovf;
    int n;
    int lat;
    logic [DW-1:0] bias;

    RST = 1'b0;
    START = 1'b0;
    SIZE_IN = '0;
    BIAS_IN = '0;
    DATA_IN_ENABLE = 1'b0;
    W_IN = '0;
    X_IN = '0;
    start_hold = 1'b0;
    last_out = '0;
    last_ovf = 1'b0;
    for (int i = 0; i < 17; i++) op_stall[i] = 0;

    vecs[0] = mk(3, ONE, 64'h10000, 64'h20000, 64'h30000, 64'h8000, 64'h8000, 64'h10000,
                 0, 1'b0, 64'h58000, 1'b0, 4);
    vecs[1] = mk(0, -64'sd131072, '0, '0, '0, '0, '0, '0, 0, 1'b0, -64'sd131072, 1'b0, 1);
    vecs[2] = mk(2, 64'h4000, 64'h20000, -64'sd98304, '0, 64'h30000, 64'h20000, '0,
                 3, 1'b0, 64'h34000, 1'b0, 6);
    vecs[3] = mk(1, MAX64, ONE, '0, '0, ONE, '0, '0, 0, 1'b0,
                 SAT ? MAX64 : 64'h8000_0000_0000_FFFF, 1'b1, 2);
    vecs[4] = mk(1, '0, 64'h4000_0000_0000_0000, '0, '0, 64'h40000, '0, '0, 0, 1'b0,
                 SAT ? MAX64 : 64'h0, 1'b1, 2);
    vecs[5] = mk(1, MIN64, -64'sd65536, '0, '0, ONE, '0, '0, 0, 1'b0,
                 SAT ? MIN64 : 64'h7FFF_FFFF_FFFF_0000, 1'b1, 2);
    vecs[6] = mk(2, '0, ONE, ONE, '0, ONE, 64'h20000, '0, 0, 1'b1, 64'h30000, 1'b0, 3);
    vecs[7] = mk(1, 64'h8000, 64'h30000, '0, '0, -64'sd32768, '0, '0, 0, 1'b0,
                 -64'sd65536, 1'b0, 2);

    #1;
    check64("reset_data_out", DATA_OUT, '0);
    check_int("reset_ready", int'(READY), 0);
    check_int("reset_data_enable", int'(DATA_ENABLE), 0);
    check_int("reset_overflow", int'(OVERFLOW_OUT), 0);
    check_int("reset_state", int'(debug_state), 0);
    repeat (2) @(negedge CLK);
    RST = 1'b1;

    // Directed table; consecutive entries start in the cycle right after READY.
    for (int v = 0; v < 8; v++) begin
      for (int j = 0; j < 3; j++) begin
        op_w[j] = vecs[v].w[j];
        op_x[j] = vecs[v].x[j];
      end
      op_stall[1] = vecs[v].stall1;
      start_hold = vecs[v].hold;
      do_vec($sformatf("vec%0d", v), vecs[v].n, vecs[v].bias,
             vecs[v].exp_out, vecs[v].exp_ovf, vecs[v].exp_lat);
      op_stall[1] = 0;
      start_hold = 1'b0;
    end

    // Reset in the middle of a 3-pair operation.
    @(negedge CLK);
    check64("pre_abort_hold", DATA_OUT, last_out);
    START = 1'b1;
    SIZE_IN = 4'd3;
    BIAS_IN = 64'h50000;
    @(negedge CLK);
    START = 1'b0;
    DATA_IN_ENABLE = 1'b1;
    W_IN = 64'h20000;
    X_IN = 64'h20000;
    @(negedge CLK);
    W_IN = 64'h30000;
    #1;
    RST = 1'b0;
    #1;
    check64("abort_data_out", DATA_OUT, '0);
    check_int("abort_ready", int'(READY), 0);
    check_int("abort_data_enable", int'(DATA_ENABLE), 0);
    check_int("abort_overflow", int'(OVERFLOW_OUT), 0);
    check_int("abort_state", int'(debug_state), 0);
    for (int k = 0; k < 4; k++) begin
      @(negedge CLK);
      check_int("abort_no_ready", int'(READY), 0);
    end
    DATA_IN_ENABLE = 1'b0;
    RST = 1'b1;
    last_out = '0;
    last_ovf = 1'b0;
    op_w[0] = 64'h28000;
    op_x[0] = -64'sd131072;
    do_vec("after_abort", 1, ONE, -64'sd262144, 1'b0, 2);

    // Randomized operations against the reference model.
    for (int t = 0; t < 40; t++) begin
      n = (t == 0) ? 15 : $urandom_range(0, 8);
      bias = rand_val(10);
      for (int i = 0; i < 16; i++) begin
        op_w[i] = rand_val(15);
        op_x[i] = rand_val(15);
        op_stall[i] = ($urandom_range(0, 99) < 30) ? $urandom_range(1, 3) : 0;
      end
      start_hold = ($urandom_range(0, 9) == 0);
      lat = n + 1;
      for (int i = 0; i < n; i++) lat += op_stall[i];
      ref_model(n, bias, exp_out, exp_ovf);
      do_vec($sformatf("rand%0d", t), n, bias, exp_out, exp_ovf, lat);
      start_hold = 1'b0;
    end

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
